// File: rtl/adiv5_pkg.sv
// Shared ADIv5 command/response encodings used by the memory-AP sequencer
// and the downstream JTAG-DP command engine.
package adiv5_pkg;

  localparam logic [2:0] STAT_OK    = 3'b100;
  localparam logic [2:0] STAT_WAIT  = 3'b010;
  localparam logic [2:0] STAT_FAULT = 3'b001;

  // A[3:2] selects; DP and AP spaces overlap, APnDP tells them apart.
  localparam logic [1:0] A_DP_SELECT = 2'b10;
  localparam logic [1:0] A_DP_RDBUFF = 2'b11;
  localparam logic [1:0] A_AP_CSW    = 2'b00;
  localparam logic [1:0] A_AP_TAR    = 2'b01;
  localparam logic [1:0] A_AP_DRW    = 2'b11;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'd0,
    SIZE_HALF    = 2'd1,
    SIZE_WORD    = 2'd2,
    SIZE_ILLEGAL = 2'd3
  } size_e;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  a;
    logic        apndp;
    logic        rnw;
  } cmd_t;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  stat;
  } rsp_t;

  function automatic logic req_legal(input size_e size, input logic [31:0] addr);
    logic ok;
    ok = 1'b0;
    case (size)
      SIZE_BYTE: ok = 1'b1;
      SIZE_HALF: ok = ~addr[0];
      SIZE_WORD: ok = (addr[1:0] == 2'b00);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/adiv5_mem_ap.sv
// Memory-AP sequencer: turns single bus reads/writes into the minimal run of
// DP/AP commands, keeping SELECT, CSW and TAR cached between requests.
module adiv5_mem_ap
  import adiv5_pkg::*;
#(
  parameter logic [7:0]  AP_SEL   = 8'h00,
  parameter logic [31:0] CSW_BASE = 32'h2300_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic [1:0]  REQ_SIZE,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic        RSP_ERR,
  output logic [31:0] RSP_RDATA,
  output logic [35:0] CMD_WRDATA,
  output logic        CMD_WREN,
  input  logic        CMD_WRFULL,
  input  logic [34:0] RSP_RDDATA,
  output logic        RSP_RDEN,
  input  logic        RSP_RDEMPTY
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  // Step order matters: the sequencer only ever moves to a higher step.
  localparam logic [2:0] STEP_SEL    = 3'd0;
  localparam logic [2:0] STEP_CSW    = 3'd1;
  localparam logic [2:0] STEP_TAR    = 3'd2;
  localparam logic [2:0] STEP_DRW    = 3'd3;
  localparam logic [2:0] STEP_RDBUFF = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic        write_q, write_d;
  size_e       size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        sel_valid_q, sel_valid_d;
  logic        csw_valid_q, csw_valid_d;
  size_e       csw_size_q, csw_size_d;
  logic        tar_valid_q, tar_valid_d;
  logic [31:0] tar_q, tar_d;
  logic        err_q, err_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [4:0]  need;
  logic [2:0]  first_step;
  logic [2:0]  after_step;
  logic        has_after;
  logic [31:0] tar_next;
  cmd_t        cmd;
  rsp_t        rsp;

  assign rsp      = rsp_t'(RSP_RDDATA);
  assign tar_next = tar_q + (32'd1 << size_q);

  assign need = {~write_q,
                 1'b1,
                 ~(tar_valid_q && (tar_q == addr_q)),
                 ~(csw_valid_q && (csw_size_q == size_q)),
                 ~sel_valid_q};

  always_comb begin
    first_step = STEP_DRW;
    has_after  = 1'b0;
    after_step = STEP_DRW;
    for (int i = 4; i >= 0; i--) begin
      if (need[i]) begin
        first_step = 3'(i);
      end
      if (need[i] && (3'(i) > step_q)) begin
        has_after  = 1'b1;
        after_step = 3'(i);
      end
    end
  end

  always_comb begin
    cmd = '0;
    case (step_q)
      STEP_SEL: begin
        cmd.a    = A_DP_SELECT;
        cmd.data = {AP_SEL, 24'h00_0000};
      end
      STEP_CSW: begin
        cmd.a     = A_AP_CSW;
        cmd.apndp = 1'b1;
        cmd.data  = CSW_BASE | 32'h0000_0010 | {30'd0, size_q};
      end
      STEP_TAR: begin
        cmd.a     = A_AP_TAR;
        cmd.apndp = 1'b1;
        cmd.data  = addr_q;
      end
      STEP_DRW: begin
        cmd.a     = A_AP_DRW;
        cmd.apndp = 1'b1;
        cmd.rnw   = ~write_q;
        cmd.data  = write_q ? wdata_q : 32'h0;
      end
      default: begin
        cmd.a   = A_DP_RDBUFF;
        cmd.rnw = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    write_d     = write_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_valid_d = sel_valid_q;
    csw_valid_d = csw_valid_q;
    csw_size_d  = csw_size_q;
    tar_valid_d = tar_valid_q;
    tar_d       = tar_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (REQ_VALID && ready_q) begin
          write_d = REQ_WRITE;
          size_d  = size_e'(REQ_SIZE);
          addr_d  = REQ_ADDR;
          wdata_d = REQ_WDATA;
          err_d   = 1'b0;
          rdata_d = 32'h0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!req_legal(size_q, addr_q)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          step_d  = first_step;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!CMD_WRFULL) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!RSP_RDEMPTY) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (rsp.stat == STAT_OK) begin
          case (step_q)
            STEP_SEL: sel_valid_d = 1'b1;
            STEP_CSW: begin
              csw_valid_d = 1'b1;
              csw_size_d  = size_q;
            end
            STEP_TAR: begin
              tar_valid_d = 1'b1;
              tar_d       = addr_q;
            end
            STEP_DRW: begin
              // The AP auto-increment only wraps within a 1 KB window.
              if (tar_next[31:10] != tar_q[31:10]) begin
                tar_valid_d = 1'b0;
              end else begin
                tar_d = tar_next;
              end
            end
            default: rdata_d = rsp.data;
          endcase
          if (has_after) begin
            step_d  = after_step;
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          err_d       = 1'b1;
          sel_valid_d = 1'b0;
          csw_valid_d = 1'b0;
          tar_valid_d = 1'b0;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ready_d = (state_d == S_IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      step_q      <= STEP_SEL;
      write_q     <= 1'b0;
      size_q      <= SIZE_BYTE;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      sel_valid_q <= 1'b0;
      csw_valid_q <= 1'b0;
      csw_size_q  <= SIZE_BYTE;
      tar_valid_q <= 1'b0;
      tar_q       <= 32'h0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      write_q     <= write_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_valid_q <= sel_valid_d;
      csw_valid_q <= csw_valid_d;
      csw_size_q  <= csw_size_d;
      tar_valid_q <= tar_valid_d;
      tar_q       <= tar_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign REQ_READY  = ready_q;
  assign RSP_VALID  = rsp_valid_q;
  assign RSP_ERR    = rsp_err_q;
  assign RSP_RDATA  = rdata_q;
  assign CMD_WRDATA = cmd;
  assign CMD_WREN   = (state_q == S_ISSUE) && !CMD_WRFULL && !RESET;
  assign RSP_RDEN   = (state_q == S_WAIT) && !RSP_RDEMPTY && !RESET;

endmodule

// File: doc/adiv5_mem_ap.md
Name: adiv5_mem_ap

Overview:
- Upstream sequencer that turns single 32-bit-addressed memory read/write requests into ADIv5 DP/AP command words for the jtag_adiv5 command FIFO.
- Consumes that block's response FIFO.
- Caches SELECT, CSW and TAR so that repeated and sequential accesses issue the minimum number of commands.
- Sits between the AHB3-lite remote bridge front end and jtag_adiv5.

Parameters:
AP_SEL, 8'h00, APSEL field written into DP SELECT[31:24].
CSW_BASE, 32'h2300_0000, CSW value OR'd with {AddrInc=2'b01 at [5:4], Size at [2:0]}.

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
REQ_VALID  in  1  request valid
REQ_READY  out  1  block idle; a request is accepted when VALID&READY
REQ_WRITE  in  1  1=write, 0=read
REQ_SIZE  in  2  0=byte, 1=half, 2=word, 3=illegal
REQ_ADDR  in  32  byte address
REQ_WDATA  in  32  write data, already lane-aligned by the caller
RSP_VALID  out  1  one-cycle completion pulse
RSP_ERR  out  1  valid with RSP_VALID; 1=fault/illegal
RSP_RDATA  out  32  read data, valid with RSP_VALID
CMD_WRDATA  out  36  {DATA[31:0], A[3:2], APnDP, RnW}
CMD_WREN  out  1  command push
CMD_WRFULL  in  1  command FIFO full
RSP_RDDATA  in  35  {DATA[31:0], STAT[2:0]}
RSP_RDEN  out  1  response pop
RSP_RDEMPTY  in  1  response FIFO empty

Behaviour:
- Reset values:
  - REQ_READY=0 during reset, 1 the cycle after reset deasserts.
  - RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0, CMD_WREN=0, RSP_RDEN=0.
  - sel_valid, csw_valid and tar_valid cleared.
- Request acceptance:
  - On accept, latch write, size, addr and wdata; REQ_READY drops until RSP_VALID.
  - Illegal request (size 3, or addr not aligned to 1<<size): RSP_VALID=1 with RSP_ERR=1 exactly 2 cycles after accept; no commands issued; caches unchanged.
- Command sequence (each step is skipped when its cache hits):
  - SELECT: DP write A=2'b10, data {AP_SEL, 16'h0, 4'h0 bank, 4'h0}. Skipped if sel_valid.
  - CSW: AP write A=2'b00, data CSW_BASE | 32'h10 | size. Skipped if csw_valid and cached size matches.
  - TAR: AP write A=2'b01, data addr. Skipped if tar_valid and cached TAR equals addr.
  - DRW: AP access A=2'b11, RnW=!write, data wdata (0 for reads).
  - Reads only: RDBUFF, DP read A=2'b11, data 0. RSP_RDATA takes DATA from this response.
- Handshake per command:
  - ISSUE: when !CMD_WRFULL, drive CMD_WRDATA and pulse CMD_WREN for exactly 1 cycle.
  - WAIT: when !RSP_RDEMPTY, pulse RSP_RDEN for 1 cycle.
  - CAPTURE: sample RSP_RDDATA on the cycle after RDEN.
  - Exactly one command is outstanding at any time.
- States: IDLE, CHECK, ISSUE, WAIT, CAPTURE, DONE.
  - A step register (SEL, CSW, TAR, DRW, RDBUFF) selects the payload.
  - CAPTURE with STAT==3'b100: update the cache for that step, then advance the step or go to DONE.
  - CAPTURE with any other STAT (001 fault/abort, 010 residual WAIT): RSP_ERR=1, clear all three valid flags, go to DONE.
- DONE: RSP_VALID pulse for 1 cycle, then IDLE with REQ_READY=1.
- TAR tracking after a successful DRW:
  - next = TAR + (1<<size), 32-bit wrap.
  - If next[31:10] != TAR[31:10], clear tar_valid (1 KB auto-increment boundary).
  - Otherwise the cached TAR becomes next.
- Best-case latency, all caches hit:
  - Write: 1 DRW command.
  - Read: DRW + RDBUFF.
  - Per command: minimum 3 cycles plus downstream time.
- Back-pressure: CMD_WRFULL held high keeps ISSUE stalled with CMD_WREN=0; the command is pushed only when full drops.
- Reset mid-operation: state returns to IDLE, caches are invalidated, and in-flight responses are not tracked. The integrator resets jtag_adiv5 together with this block.

Decomposition:
- Shared package adiv5_pkg:
  - STAT codes: OK=3'b100, WAIT=3'b010, FAULT=3'b001.
  - Packed cmd_t {data, a, apndp, rnw} (36 b) and rsp_t {data, stat} (35 b).
  - DP/AP register A[3:2] constants: SELECT, RDBUFF, CSW, TAR, DRW.
  - Size enum.
- No sub-module: a single FSM plus cache registers.

Test Plan:
- Cold write word 0x2000_0000 = 0xDEAD_BEEF, all responses OK:
  - Commands: SELECT 0x0000_0000, CSW 0x2300_0012, TAR 0x2000_0000, DRW write 0xDEAD_BEEF.
  - RSP_ERR=0.
- Follow-up read word 0x2000_0004, RDBUFF returns 0x1234_5678:
  - Commands: DRW read then RDBUFF only (TAR hit via auto-increment).
  - RSP_RDATA=0x1234_5678.
- Word write at 0x2000_03FC, then write at 0x2000_0400:
  - The second write re-issues TAR 0x2000_0400 (boundary invalidation).
- Byte read at 0x2000_0001 after word accesses:
  - Commands: CSW 0x2300_0010, TAR, DRW, RDBUFF.
  - A half access at 0x2000_0001 gives RSP_ERR=1 and no CMD_WREN.
- DRW response STAT=001:
  - RSP_ERR=1.
  - The next request re-issues SELECT, CSW and TAR.
- CMD_WRFULL held high 20 cycles during ISSUE:
  - No CMD_WREN until release.
  - Exactly one push after release.
  - RESET asserted mid-WAIT returns REQ_READY=1 and the next request starts from SELECT.
